mem_arbiter: RTL and testbench

Arbitrates one single-ported unified memory between the pipelined core's fetch stage (I side) and memory stage (D side). It issues one memory transaction at a time over a req/ack handshake and returns completion and read data to the winning requester. It also generates the stall signals that the hazard logic ORs into the fetch and memory-stage stalls. D requests have priority over I requests, and a streak counter prevents fetch starvation.

---
 rtl/mem_arbiter.sv | 108 ++++++++++
 tb/tb_mem_arbiter.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates one single-ported memory between the fetch (I) and memory-stage (D) requesters.
// D has priority; a streak counter forces an I grant after STARVE consecutive D grants.
module mem_arbiter #(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter int unsigned STARVE = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ireq,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] irdata,
  output logic          iready,
  output logic          stallF,
  input  logic          dreq,
  input  logic          dwe,
  input  logic [AW-1:0] daddr,
  input  logic [DW-1:0] dwdata,
  output logic [DW-1:0] drdata,
  output logic          dready,
  output logic          stallM,
  output logic          mreq,
  output logic          mwe,
  output logic [AW-1:0] maddr,
  output logic [DW-1:0] mwdata,
  input  logic [DW-1:0] mrdata,
  input  logic          mack
);

  localparam int unsigned SW = $clog2(STARVE + 1);
  localparam logic [SW-1:0] StarveMax = SW'(STARVE);

  typedef enum logic [1:0] {StIdle, StIBusy, StDBusy} state_t;

  state_t        stateQ, stateD;
  logic [SW-1:0] streakQ, streakD;
  logic          mreqD, mweD;
  logic [AW-1:0] maddrD;
  logic [DW-1:0] mwdataD;
  logic          iStarved;

  assign iStarved = ireq && (streakQ == StarveMax);

  always_comb begin
    stateD  = stateQ;
    streakD = streakQ;
    mreqD   = mreq;
    mweD    = mwe;
    maddrD  = maddr;
    mwdataD = mwdata;
    case (stateQ)
      StIdle: begin
        if (dreq && !iStarved) begin
          stateD  = StDBusy;
          mreqD   = 1'b1;
          mweD    = dwe;
          maddrD  = daddr;
          mwdataD = dwdata;
          if (!ireq)                   streakD = '0;
          else if (streakQ != StarveMax) streakD = streakQ + SW'(1);
        end else if (ireq) begin
          stateD  = StIBusy;
          mreqD   = 1'b1;
          mweD    = 1'b0;
          maddrD  = iaddr;
          mwdataD = '0;
          streakD = '0;
        end
      end
      StIBusy, StDBusy: begin
        // Address and write data are left as-is after completion.
        if (mack) begin
          stateD = StIdle;
          mreqD  = 1'b0;
          mweD   = 1'b0;
        end
      end
      default: stateD = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stateQ  <= StIdle;
      streakQ <= '0;
      mreq    <= 1'b0;
      mwe     <= 1'b0;
      maddr   <= '0;
      mwdata  <= '0;
    end else begin
      stateQ  <= stateD;
      streakQ <= streakD;
      mreq    <= mreqD;
      mwe     <= mweD;
      maddr   <= maddrD;
      mwdata  <= mwdataD;
    end
  end

  // Completion is combinational so the pipeline advances on the same edge as mack.
  assign iready = (stateQ == StIBusy) && mack;
  assign dready = (stateQ == StDBusy) && mack;
  assign irdata = mrdata;
  assign drdata = mrdata;
  assign stallF = ireq && !iready;
  assign stallM = dreq && !dready;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus randomized traffic
// compared against a transaction-level ownership model.
module tb_mem_arbiter;
  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned STARVE = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          ireq, dreq, dwe, mack;
  logic [AW-1:0] iaddr, daddr;
  logic [DW-1:0] dwdata, mrdata;
  logic [DW-1:0] irdata, drdata, mwdata;
  logic [AW-1:0] maddr;
  logic          iready, dready, stallF, stallM, mreq, mwe;

  int total = 0;
  int bad = 0;

  mem_arbiter #(.AW(AW), .DW(DW), .STARVE(STARVE)) dut (
    .clk(clk), .reset(reset),
    .ireq(ireq), .iaddr(iaddr), .irdata(irdata), .iready(iready), .stallF(stallF),
    .dreq(dreq), .dwe(dwe), .daddr(daddr), .dwdata(dwdata), .drdata(drdata),
    .dready(dready), .stallM(stallM),
    .mreq(mreq), .mwe(mwe), .maddr(maddr), .mwdata(mwdata), .mrdata(mrdata), .mack(mack)
  );

  always #5 clk = ~clk;

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    ireq = 1'b0; dreq = 1'b0; mack = 1'b0;
    reset = 1'b0;
    nextCycle();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; ireq = 1'b1; dreq = 1'b0; dwe = 1'b0; mack = 1'b1;
    iaddr = '0; daddr = '0; dwdata = '0; mrdata = 32'h1234;
    #2;
    total++;
    if ({mreq, mwe, iready, dready, stallF, stallM} !== 6'b000010) begin
      bad++;
      $display("FAIL reset_ctl got=%b exp=000010",
               {mreq, mwe, iready, dready, stallF, stallM});
    end
    total++;
    if ({maddr, mwdata} !== 64'h0) begin
      bad++;
      $display("FAIL reset_regs got maddr=%h mwdata=%h exp 0", maddr, mwdata);
    end
    ireq = 1'b0; mack = 1'b0;
    nextCycle();
    reset = 1'b1;
  endtask

  task automatic test_single_fetch();
    ireq = 1'b1; iaddr = 32'h40;
    for (int c = 0; c <= 4; c++) begin
      mack = (c == 3);
      mrdata = (c == 3) ? 32'h8C020004 : 32'h0;
      if (c == 4) ireq = 1'b0;
      @(negedge clk);
      total++;
      if ({mreq, mwe, iready, stallF} !== {c >= 1 && c <= 3, 1'b0, c == 3, c <= 2}) begin
        bad++;
        $display("FAIL fetch_ctl c=%0d got=%b exp=%b", c, {mreq, mwe, iready, stallF},
                 {c >= 1 && c <= 3, 1'b0, c == 3, c <= 2});
      end
      if (c >= 1 && c <= 3) begin
        total++;
        if (maddr !== 32'h40) begin
          bad++;
          $display("FAIL fetch_addr c=%0d got=%h exp=40", c, maddr);
        end
      end
      if (c == 3) begin
        total++;
        if (irdata !== 32'h8C020004) begin
          bad++;
          $display("FAIL fetch_data got=%h exp=8c020004", irdata);
        end
      end
      nextCycle();
    end
  endtask

  task automatic test_store();
    dreq = 1'b1; dwe = 1'b1; daddr = 32'h100; dwdata = 32'hDEADBEEF;
    for (int c = 0; c <= 2; c++) begin
      mack = (c == 1);
      if (c == 2) dreq = 1'b0;
      @(negedge clk);
      total++;
      if ({mreq, mwe, dready, stallM} !== {c == 1, c == 1, c == 1, c == 0}) begin
        bad++;
        $display("FAIL store_ctl c=%0d got=%b exp=%b", c, {mreq, mwe, dready, stallM},
                 {c == 1, c == 1, c == 1, c == 0});
      end
      if (c >= 1) begin
        total++;
        if ({maddr, mwdata} !== {32'h100, 32'hDEADBEEF}) begin
          bad++;
          $display("FAIL store_bus c=%0d got=%h/%h exp=100/deadbeef", c, maddr, mwdata);
        end
      end
      nextCycle();
    end
    dwe = 1'b0;
  endtask

  task automatic test_conflict();
    ireq = 1'b1; iaddr = 32'hA0; dreq = 1'b1; daddr = 32'hB0; dwe = 1'b0;
    for (int c = 0; c <= 4; c++) begin
      mack = (c == 1) || (c == 3);
      mrdata = 32'h100 + c;
      if (c == 2) dreq = 1'b0;
      if (c == 4) ireq = 1'b0;
      @(negedge clk);
      total++;
      if ({mreq, dready, iready, stallF} !==
          {c == 1 || c == 3, c == 1, c == 3, c <= 2}) begin
        bad++;
        $display("FAIL conflict_ctl c=%0d got=%b exp=%b", c, {mreq, dready, iready, stallF},
                 {c == 1 || c == 3, c == 1, c == 3, c <= 2});
      end
      if (c == 1 || c == 3) begin
        total++;
        if (maddr !== ((c == 1) ? 32'hB0 : 32'hA0)) begin
          bad++;
          $display("FAIL conflict_addr c=%0d got=%h exp=%h", c, maddr,
                   (c == 1) ? 32'hB0 : 32'hA0);
        end
      end
      nextCycle();
    end
  endtask

  task automatic test_reset_mid();
    dreq = 1'b1; dwe = 1'b1; daddr = 32'h300; dwdata = 32'h12345678; mack = 1'b0;
    nextCycle();
    @(negedge clk);
    total++;
    if ({mreq, mwe} !== 2'b11) begin
      bad++;
      $display("FAIL rstmid_busy got=%b exp=11", {mreq, mwe});
    end
    mack = 1'b1;
    #1 reset = 1'b0;
    #1;
    total++;
    if ({mreq, mwe, dready, stallM} !== 4'b0001) begin
      bad++;
      $display("FAIL rstmid_abort got=%b exp=0001", {mreq, mwe, dready, stallM});
    end
    mack = 1'b0;
    nextCycle();
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (mreq !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_idle got=%b exp=0", mreq);
    end
    nextCycle();
    @(negedge clk);
    mack = 1'b1;
    #1;
    total++;
    if ({mreq, mwe, dready, maddr} !== {3'b111, 32'h300}) begin
      bad++;
      $display("FAIL rstmid_regrant got=%b/%h exp=111/300", {mreq, mwe, dready}, maddr);
    end
    nextCycle();
    dreq = 1'b0; dwe = 1'b0; mack = 1'b0;
    nextCycle();
  endtask

  task automatic test_flush();
    ireq = 1'b1; iaddr = 32'h80;
    nextCycle();
    ireq = 1'b0;
    @(negedge clk);
    total++;
    if ({mreq, stallF, iready} !== 3'b100) begin
      bad++;
      $display("FAIL flush_busy got=%b exp=100", {mreq, stallF, iready});
    end
    nextCycle();
    mack = 1'b1; mrdata = 32'h55;
    @(negedge clk);
    total++;
    if ({iready, irdata} !== {1'b1, 32'h55}) begin
      bad++;
      $display("FAIL flush_ready got=%b/%h exp=1/55", iready, irdata);
    end
    nextCycle();
    mack = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      total++;
      if (mreq !== 1'b0) begin
        bad++;
        $display("FAIL flush_nogrant c=%0d got=%b exp=0", c, mreq);
      end
      nextCycle();
    end
  endtask

  task automatic test_starvation();
    logic got[10];
    int   n = 0;
    logic prev = 1'b0;
    doReset();
    ireq = 1'b1; dreq = 1'b1; iaddr = 32'h1000; daddr = 32'h2000; dwe = 1'b0;
    for (int c = 0; c < 200 && n < 10; c++) begin
      mack = mreq;
      @(negedge clk);
      if (mreq && !prev) begin
        got[n] = (maddr == 32'h2000);
        n++;
      end
      prev = mreq;
      nextCycle();
    end
    total++;
    if (n != 10) begin
      bad++;
      $display("FAIL starve_timeout got=%0d grants exp=10", n);
    end
    for (int k = 0; k < n; k++) begin
      total++;
      if (got[k] !== ((k % (STARVE + 1)) != STARVE)) begin
        bad++;
        $display("FAIL starve_order k=%0d got_d=%b exp_d=%b", k, got[k],
                 (k % (STARVE + 1)) != STARVE);
      end
    end
    ireq = 1'b0; dreq = 1'b0; mack = 1'b0;
    nextCycle();
    nextCycle();
  endtask

  // Model tracks who owns the memory and how many D grants happened while I waited.
  task automatic test_random();
    int            owner = 0;  // 0 none, 1 I, 2 D
    int            streak = 0;
    logic          eWe = 1'b0;
    logic [AW-1:0] eAddr = '0;
    logic [DW-1:0] eWdata = '0;
    logic          eI, eD, iDone, dDone;
    iDone = 1'b0; dDone = 1'b0;
    doReset();
    for (int c = 0; c < 2000; c++) begin
      if (iDone) ireq = 1'b0;
      else if (!ireq && $urandom_range(0, 2) == 0) begin
        ireq = 1'b1; iaddr = $urandom;
      end
      if (dDone) dreq = 1'b0;
      else if (!dreq && $urandom_range(0, 2) == 0) begin
        dreq = 1'b1; daddr = $urandom; dwdata = $urandom; dwe = $urandom_range(0, 1) == 1;
      end
      mack = (owner != 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 7) == 0);
      mrdata = $urandom;
      @(negedge clk);
      eI = (owner == 1) && mack;
      eD = (owner == 2) && mack;
      total++;
      if ({mreq, mwe, iready, dready, stallF, stallM} !==
          {owner != 0, eWe, eI, eD, ireq && !eI, dreq && !eD}) begin
        bad++;
        $display("FAIL rand_ctl c=%0d got=%b exp=%b", c,
                 {mreq, mwe, iready, dready, stallF, stallM},
                 {owner != 0, eWe, eI, eD, ireq && !eI, dreq && !eD});
      end
      total++;
      if ({maddr, mwdata} !== {eAddr, eWdata}) begin
        bad++;
        $display("FAIL rand_bus c=%0d got=%h/%h exp=%h/%h", c, maddr, mwdata, eAddr, eWdata);
      end
      if (eI || eD) begin
        total++;
        if ((eI ? irdata : drdata) !== mrdata) begin
          bad++;
          $display("FAIL rand_rdata c=%0d got=%h exp=%h", c, eI ? irdata : drdata, mrdata);
        end
      end
      iDone = eI; dDone = eD;
      if (owner == 0) begin
        if (dreq && !(ireq && streak == STARVE)) begin
          owner = 2; eWe = dwe; eAddr = daddr; eWdata = dwdata;
          streak = ireq ? ((streak < STARVE) ? streak + 1 : streak) : 0;
        end else if (ireq) begin
          owner = 1; eWe = 1'b0; eAddr = iaddr; eWdata = '0; streak = 0;
        end
      end else if (mack) begin
        owner = 0; eWe = 1'b0;
      end
      nextCycle();
    end
    ireq = 1'b0; dreq = 1'b0; mack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_fetch();
    test_store();
    test_conflict();
    test_reset_mid();
    test_flush();
    test_starvation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
